adc_sequencer: RTL

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_sequencer.sv
// ADC scan sequencer: powers the ADC, settles, then converts each channel set in a latched mask.
// Define ADC_SEQ_TIMEOUT_EN to bound each conversion wait by TIMEOUT_CYCLES.
module adc_sequencer #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int SETTLE_CYCLES  = 32,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NUM_CHANNELS-1:0] chan_mask,
   output logic                    busy,
   output logic                    done,
   output logic                    adc_enable,
   output logic                    adc_read,
   output logic [CW-1:0]           adc_sel,
   input  logic                    adc_conversion_complete,
   input  logic [DATA_WIDTH-1:0]   adc_value,
   output logic                    result_valid,
   output logic [CW-1:0]           result_chan,
   output logic [DATA_WIDTH-1:0]   result_data,
   output logic                    timeout_err
);

   // state  | meaning
   // IDLE   | waiting for start
   // SETTLE | adc_enable high, waiting SETTLE_CYCLES before the first read
   // READ   | adc_read high on adc_sel, waiting for completion
   // GAP    | adc_read low for GAP_CYCLES between reads
   // FINISH | drop enable/busy, pulse done
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam int SG_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int CNT_MAX = (TIMEOUT_CYCLES > SG_MAX) ? TIMEOUT_CYCLES : SG_MAX;
`else
   localparam int CNT_MAX = SG_MAX;
`endif
   localparam int CNTW = $clog2(CNT_MAX + 1);

   localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYCLES - 1);
   localparam logic [CNTW-1:0] GAP_LOAD    = CNTW'(GAP_CYCLES - 1);
`ifdef ADC_SEQ_TIMEOUT_EN
   localparam logic [CNTW-1:0] READ_LOAD   = CNTW'(TIMEOUT_CYCLES - 1);
`else
   localparam logic [CNTW-1:0] READ_LOAD   = '0;
`endif

   logic [2:0]              state_q, state_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [NUM_CHANNELS-1:0] mask_q, mask_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    en_q, en_d;
   logic                    rd_q, rd_d;
   logic [CW-1:0]           sel_q, sel_d;
   logic                    rv_q, rv_d;
   logic [CW-1:0]           rchan_q, rchan_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    terr_q, terr_d;

   logic [CW-1:0]           first_ch;
   logic [CW-1:0]           next_ch;
   logic                    next_found;

   // Descending scans so the lowest qualifying channel wins.
   always_comb begin
      first_ch   = '0;
      next_ch    = '0;
      next_found = 1'b0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_ch = CW'(i);
            if (i > int'(sel_q)) begin
               next_ch    = CW'(i);
               next_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
      mask_d  = mask_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      en_d    = en_q;
      rd_d    = rd_q;
      sel_d   = sel_q;
      rv_d    = 1'b0;
      rchan_d = rchan_q;
      rdata_d = rdata_q;
      terr_d  = terr_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               mask_d = chan_mask;
               terr_d = 1'b0;
               busy_d = 1'b1;
               if (chan_mask != '0) begin
                  state_d = S_SETTLE;
                  en_d    = 1'b1;
                  cnt_d   = SETTLE_LOAD;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_READ;
               rd_d    = 1'b1;
               sel_d   = first_ch;
               cnt_d   = READ_LOAD;
            end
         end
         S_READ: begin
            if (adc_conversion_complete) begin
               rdata_d = adc_value;
               rchan_d = sel_q;
               rv_d    = 1'b1;
               rd_d    = 1'b0;
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
            end
`ifdef ADC_SEQ_TIMEOUT_EN
            else if (cnt_q == '0) begin
               terr_d  = 1'b1;
               rd_d    = 1'b0;
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
            end
`endif
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               if (next_found) begin
                  state_d = S_READ;
                  rd_d    = 1'b1;
                  sel_d   = next_ch;
                  cnt_d   = READ_LOAD;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything, including a completion on the same edge.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         en_d    = 1'b0;
         rd_d    = 1'b0;
         done_d  = 1'b0;
         rv_d    = 1'b0;
         rchan_d = rchan_q;
         rdata_d = rdata_q;
         terr_d  = terr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         rd_q    <= 1'b0;
         sel_q   <= '0;
         rv_q    <= 1'b0;
         rchan_q <= '0;
         rdata_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
         rd_q    <= rd_d;
         sel_q   <= sel_d;
         rv_q    <= rv_d;
         rchan_q <= rchan_d;
         rdata_q <= rdata_d;
         terr_q  <= terr_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign adc_enable   = en_q;
   assign adc_read     = rd_q;
   assign adc_sel      = sel_q;
   assign result_valid = rv_q;
   assign result_chan  = rchan_q;
   assign result_data  = rdata_q;
   // Never set without ADC_SEQ_TIMEOUT_EN, so this stays at its reset value of 0.
   assign timeout_err  = terr_q;

endmodule
